pc_fetch_sequencer: RTL and testbench

//  Drives the one-hot select lines of the address-logic unit and owns the PC register:

---
 rtl/pc_fetch_sequencer.sv | 167 ++++++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_sequencer
// Brief    : Owns the PC, drives one-hot address-logic selects and fetches the
//            instruction at PC over a req/ready handshake.
//            Optional macro FETCH_TIMEOUT_EN adds a fetch timeout with re-issue.
// Revision : 1.0  initial release
// ============================================================================
module pc_fetch_sequencer #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] al_out,
  output logic [ADDR_W-1:0] pc_side,
  output logic              reset_pc,
  output logic              pc_plus_i,
  output logic              pc_plus_1,
  output logic              r_plus_i,
  output logic              r_plus_0,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd,
  output logic              cmd_ready,
  input  logic              soft_rst,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] ir,
  output logic              ir_valid,
  output logic              fetch_err
);

  typedef enum logic [1:0] {
    LOAD0    = 2'd0,
    FETCH    = 2'd1,
    WAIT_CMD = 2'd2
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_ir;
  logic              r_mem_read;
  logic              r_ir_valid;
  logic              w_accept;
  logic              w_fetch_done;
  logic              w_timeout;

  if (TIMEOUT < 1) begin : g_timeout_guard
    $error("pc_fetch_sequencer: TIMEOUT must be at least 1");
  end

  // soft_rst outranks a command arriving in the same cycle
  assign w_accept     = (r_state == WAIT_CMD) && cmd_valid && !soft_rst;
  assign w_fetch_done = (r_state == FETCH) && r_mem_read && mem_ready;

  assign pc_side   = r_pc;
  assign mem_addr  = r_pc;
  assign mem_read  = r_mem_read;
  assign ir        = r_ir;
  assign ir_valid  = r_ir_valid;
  assign cmd_ready = (r_state == WAIT_CMD);

  // Selects feed al_out in the same cycle, so they cannot wait for a clock edge
  always_comb begin
    reset_pc  = (r_state == LOAD0) && !reset;
    pc_plus_1 = 1'b0;
    pc_plus_i = 1'b0;
    r_plus_i  = 1'b0;
    r_plus_0  = 1'b0;
    if (w_accept) begin
      case (cmd)
        2'b00:   pc_plus_1 = 1'b1;
        2'b01:   pc_plus_i = 1'b1;
        2'b10:   r_plus_i  = 1'b1;
        default: r_plus_0  = 1'b1;
      endcase
    end
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int c_cnt_w = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [c_cnt_w-1:0] r_cnt;
  logic               r_fetch_err;

  assign w_timeout = (r_state == FETCH) && r_mem_read && !mem_ready &&
                     (r_cnt == c_cnt_w'(TIMEOUT - 1));
  assign fetch_err = r_fetch_err;

  // Counter idles at zero outside FETCH, so every FETCH entry starts fresh
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt       <= '0;
      r_fetch_err <= 1'b0;
    end else if (soft_rst) begin
      r_cnt       <= '0;
      r_fetch_err <= 1'b0;
    end else if (r_state != FETCH) begin
      r_cnt <= '0;
    end else if (w_timeout) begin
      r_cnt       <= '0;
      r_fetch_err <= 1'b1;
    end else if (r_mem_read && !mem_ready) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign fetch_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= LOAD0;
      r_pc       <= '0;
      r_ir       <= '0;
      r_mem_read <= 1'b0;
      r_ir_valid <= 1'b0;
    end else begin
      r_ir_valid <= 1'b0;
      if (soft_rst) begin
        // Abandon any fetch in flight; ir keeps its last good value
        r_state    <= LOAD0;
        r_mem_read <= 1'b0;
        if (r_state == LOAD0) begin
          r_pc <= al_out;
        end
      end else begin
        case (r_state)
          LOAD0: begin
            r_pc       <= al_out;
            r_state    <= FETCH;
            r_mem_read <= 1'b1;
          end
          FETCH: begin
            if (w_fetch_done) begin
              r_ir       <= mem_data;
              r_ir_valid <= 1'b1;
              r_mem_read <= 1'b0;
              r_state    <= WAIT_CMD;
            end else if (w_timeout) begin
              r_mem_read <= 1'b0;
            end else begin
              r_mem_read <= 1'b1;
            end
          end
          WAIT_CMD: begin
            if (w_accept) begin
              r_pc       <= al_out;
              r_state    <= FETCH;
              r_mem_read <= 1'b1;
            end
          end
          default: begin
            r_state    <= LOAD0;
            r_mem_read <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_fetch_sequencer
// Brief    : Randomized self-checking bench for pc_fetch_sequencer with an
//            address-logic/memory environment and a next-PC reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_pc_fetch_sequencer;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] al_out;
  logic [15:0] pc_side;
  logic        reset_pc, pc_plus_i, pc_plus_1, r_plus_i, r_plus_0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd = 2'b00;
  logic        cmd_ready;
  logic        soft_rst = 1'b0;
  logic [15:0] mem_addr;
  logic        mem_read;
  logic        mem_ready = 1'b0;
  logic [15:0] mem_data = 16'h0000;
  logic [15:0] ir;
  logic        ir_valid;
  logic        fetch_err;

  logic [15:0] r_reg = 16'h0000;
  logic [15:0] i_imm = 16'h0000;
  logic [4:0]  sel_now;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] exp_pc;
  logic [15:0] exp_ir;

  pc_fetch_sequencer #(
    .ADDR_W (16),
    .DATA_W (16),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .al_out   (al_out),
    .pc_side  (pc_side),
    .reset_pc (reset_pc),
    .pc_plus_i(pc_plus_i),
    .pc_plus_1(pc_plus_1),
    .r_plus_i (r_plus_i),
    .r_plus_0 (r_plus_0),
    .cmd_valid(cmd_valid),
    .cmd      (cmd),
    .cmd_ready(cmd_ready),
    .soft_rst (soft_rst),
    .mem_addr (mem_addr),
    .mem_read (mem_read),
    .mem_ready(mem_ready),
    .mem_data (mem_data),
    .ir       (ir),
    .ir_valid (ir_valid),
    .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  assign sel_now = {reset_pc, pc_plus_i, pc_plus_1, r_plus_i, r_plus_0};

  // Address-logic environment: all selects low means pass PC through
  always_comb begin
    al_out = pc_side;
    if (reset_pc)       al_out = 16'h0000;
    else if (pc_plus_1) al_out = pc_side + 16'd1;
    else if (pc_plus_i) al_out = pc_side + i_imm;
    else if (r_plus_i)  al_out = r_reg + i_imm;
    else if (r_plus_0)  al_out = r_reg;
  end

  function automatic logic [15:0] model_next(input logic [1:0] c, input logic [15:0] pc,
                                             input logic [15:0] r, input logic [15:0] i);
    case (c)
      2'b00:   return pc + 16'd1;
      2'b01:   return pc + i;
      2'b10:   return r + i;
      default: return r;
    endcase
  endfunction

  // Order {reset_pc, pc_plus_i, pc_plus_1, r_plus_i, r_plus_0}
  function automatic logic [4:0] model_sel(input logic [1:0] c);
    case (c)
      2'b00:   return 5'b00100;
      2'b01:   return 5'b01000;
      2'b10:   return 5'b00010;
      default: return 5'b00001;
    endcase
  endfunction

  task automatic serve_fetch(input logic [15:0] data, input int lat,
                             output logic [15:0] addr, output logic ok);
    int n;
    n = 0;
    while (!mem_read && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok   = mem_read;
    addr = mem_addr;
    if (ok) begin
      repeat (lat - 1) @(negedge clk);
      mem_ready = 1'b1;
      mem_data  = data;
      @(negedge clk);
      mem_ready = 1'b0;
      mem_data  = 16'($urandom);
    end
  endtask

  task automatic issue_cmd(input logic [1:0] c, output logic [4:0] sel, output logic rdy);
    cmd_valid = 1'b1;
    cmd       = c;
    #1;
    sel = sel_now;
    rdy = cmd_ready;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd       = 2'($urandom);
  endtask

  task automatic test_reset;
    logic [15:0] addr;
    logic        ok;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({pc_side, ir} !== 32'h0) $display("FAIL reset_regs: pc/ir=%h/%h expected 0000/0000", pc_side, ir);
    else n_pass++;
    n_checks++;
    if ({sel_now, mem_read, ir_valid, fetch_err, cmd_ready} !== 9'h0)
      $display("FAIL reset_ctrl: sel=%b rd=%b v=%b err=%b rdy=%b expected all 0",
               sel_now, mem_read, ir_valid, fetch_err, cmd_ready);
    else n_pass++;
    reset = 1'b0;
    #1;
    n_checks++;
    if (sel_now !== 5'b10000) $display("FAIL load0_sel: sel=%b expected 10000", sel_now);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (sel_now !== 5'b00000) $display("FAIL load0_pulse: sel=%b expected 00000", sel_now);
    else n_pass++;
    serve_fetch(16'hABCD, 1, addr, ok);
    n_checks++;
    if ({ok, addr} !== {1'b1, 16'h0000}) $display("FAIL boot_addr: ok=%b addr=%h expected 1/0000", ok, addr);
    else n_pass++;
    n_checks++;
    if ({ir, ir_valid, cmd_ready} !== {16'hABCD, 2'b11})
      $display("FAIL boot_ir: ir=%h v=%b rdy=%b expected abcd/1/1", ir, ir_valid, cmd_ready);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({ir_valid, cmd_ready} !== 2'b01) $display("FAIL irv_pulse: v=%b rdy=%b expected 0/1", ir_valid, cmd_ready);
    else n_pass++;
    exp_pc = 16'h0000;
    exp_ir = 16'hABCD;
  endtask

  task automatic test_pc_plus_1;
    logic [15:0] addr, d;
    logic [4:0]  sel;
    logic        ok, rdy;
    r_reg = 16'h0010;
    issue_cmd(2'b11, sel, rdy);
    serve_fetch(16'h1111, 2, addr, ok);
    n_checks++;
    if ({ok, addr} !== {1'b1, 16'h0010}) $display("FAIL set_pc: ok=%b addr=%h expected 1/0010", ok, addr);
    else n_pass++;
    d = 16'($urandom);
    issue_cmd(2'b00, sel, rdy);
    n_checks++;
    if ({sel, rdy} !== {5'b00100, 1'b1}) $display("FAIL inc_sel: sel=%b rdy=%b expected 00100/1", sel, rdy);
    else n_pass++;
    n_checks++;
    if ({sel_now, pc_side} !== {5'b00000, 16'h0011})
      $display("FAIL inc_after: sel=%b pc=%h expected 00000/0011", sel_now, pc_side);
    else n_pass++;
    serve_fetch(d, 1, addr, ok);
    n_checks++;
    if ({ok, addr, ir, ir_valid} !== {1'b1, 16'h0011, d, 1'b1})
      $display("FAIL inc_fetch: addr=%h ir=%h v=%b expected 0011/%h/1", addr, ir, ir_valid, d);
    else n_pass++;
    exp_pc = 16'h0011;
    exp_ir = d;
  endtask

  task automatic test_wrap;
    logic [15:0] addr;
    logic [4:0]  sel;
    logic        ok, rdy;
    r_reg = 16'hFFFF;
    issue_cmd(2'b11, sel, rdy);
    serve_fetch(16'h2222, 1, addr, ok);
    issue_cmd(2'b00, sel, rdy);
    serve_fetch(16'h3333, 1, addr, ok);
    n_checks++;
    if ({ok, addr, fetch_err} !== {1'b1, 16'h0000, 1'b0})
      $display("FAIL wrap: addr=%h err=%b expected 0000/0", addr, fetch_err);
    else n_pass++;
    r_reg = 16'h1234;
    issue_cmd(2'b11, sel, rdy);
    n_checks++;
    if (sel !== 5'b00001) $display("FAIL r0_sel: sel=%b expected 00001", sel);
    else n_pass++;
    serve_fetch(16'h4444, 1, addr, ok);
    n_checks++;
    if ({ok, addr} !== {1'b1, 16'h1234}) $display("FAIL r0_addr: addr=%h expected 1234", addr);
    else n_pass++;
    exp_pc = 16'h1234;
    exp_ir = 16'h4444;
  endtask

  task automatic test_soft_rst;
    logic [15:0] addr, d, tgt;
    logic [4:0]  sel;
    logic        ok, rdy;
    // soft_rst together with a command in WAIT_CMD
    soft_rst  = 1'b1;
    cmd_valid = 1'b1;
    cmd       = 2'b00;
    @(negedge clk);
    soft_rst  = 1'b0;
    cmd_valid = 1'b0;
    n_checks++;
    if ({pc_side, mem_read, cmd_ready} !== {exp_pc, 2'b00})
      $display("FAIL srst_cmd: pc=%h rd=%b rdy=%b expected %h/0/0", pc_side, mem_read, cmd_ready, exp_pc);
    else n_pass++;
    serve_fetch(16'h5A5A, 1, addr, ok);
    n_checks++;
    if ({ok, addr} !== {1'b1, 16'h0000}) $display("FAIL srst_cmd_addr: addr=%h expected 0000", addr);
    else n_pass++;
    exp_ir = 16'h5A5A;
    // soft_rst during FETCH with mem_ready in the same cycle
    i_imm = 16'($urandom_range(1, 16'hFFF0));
    tgt   = model_next(2'b01, 16'h0000, r_reg, i_imm);
    issue_cmd(2'b01, sel, rdy);
    n_checks++;
    if ({mem_read, mem_addr} !== {1'b1, tgt}) $display("FAIL srst_pre: rd=%b addr=%h expected 1/%h", mem_read, mem_addr, tgt);
    else n_pass++;
    soft_rst  = 1'b1;
    mem_ready = 1'b1;
    mem_data  = ~exp_ir;
    @(negedge clk);
    soft_rst  = 1'b0;
    mem_ready = 1'b0;
    n_checks++;
    if ({ir, ir_valid, mem_read, cmd_ready} !== {exp_ir, 3'b000})
      $display("FAIL srst_fetch: ir=%h v=%b rd=%b rdy=%b expected %h/0/0/0", ir, ir_valid, mem_read, cmd_ready, exp_ir);
    else n_pass++;
    #1;
    n_checks++;
    if (sel_now !== 5'b10000) $display("FAIL srst_load0: sel=%b expected 10000", sel_now);
    else n_pass++;
    d = 16'($urandom);
    serve_fetch(d, 2, addr, ok);
    n_checks++;
    if ({ok, addr, ir} !== {1'b1, 16'h0000, d}) $display("FAIL srst_refetch: addr=%h ir=%h expected 0000/%h", addr, ir, d);
    else n_pass++;
    exp_pc = 16'h0000;
    exp_ir = d;
  endtask

  task automatic test_cmd_during_fetch;
    logic [15:0] addr, d, pc1, pc2;
    logic [4:0]  sel;
    logic        ok, rdy;
    int          bad;
    pc1   = model_next(2'b00, exp_pc, r_reg, i_imm);
    i_imm = 16'($urandom_range(1, 16'hFFF0));
    pc2   = model_next(2'b01, pc1, r_reg, i_imm);
    d     = 16'($urandom);
    issue_cmd(2'b00, sel, rdy);
    cmd_valid = 1'b1;
    cmd       = 2'b01;
    bad       = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (sel_now !== 5'b0 || cmd_ready !== 1'b0 || pc_side !== pc1) bad++;
      if (k == 3) begin
        mem_ready = 1'b1;
        mem_data  = d;
      end
      @(negedge clk);
    end
    mem_ready = 1'b0;
    n_checks++;
    if (bad !== 0) $display("FAIL early_cmd: %0d cycles acted on cmd in FETCH expected 0", bad);
    else n_pass++;
    #1;
    n_checks++;
    if ({sel_now, ir, ir_valid} !== {5'b01000, d, 1'b1})
      $display("FAIL held_cmd: sel=%b ir=%h v=%b expected 01000/%h/1", sel_now, ir, ir_valid, d);
    else n_pass++;
    @(negedge clk);
    cmd_valid = 1'b0;
    serve_fetch(16'h7777, 3, addr, ok);
    n_checks++;
    if ({ok, addr, pc_side} !== {1'b1, pc2, pc2})
      $display("FAIL one_update: addr=%h pc=%h expected %h", addr, pc_side, pc2);
    else n_pass++;
    exp_pc = pc2;
    exp_ir = 16'h7777;
  endtask

  task automatic test_random;
    logic [15:0] addr, d, tgt;
    logic [4:0]  sel;
    logic [1:0]  c;
    logic        ok, rdy;
    int          lat;
    for (int t = 0; t < 24; t++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      n_checks++;
      if ({pc_side, cmd_ready, sel_now} !== {exp_pc, 1'b1, 5'b0})
        $display("FAIL rnd_idle[%0d]: pc=%h rdy=%b sel=%b expected %h/1/00000", t, pc_side, cmd_ready, sel_now, exp_pc);
      else n_pass++;
      c     = 2'($urandom);
      r_reg = 16'($urandom);
      i_imm = 16'($urandom);
      lat   = $urandom_range(1, 4);
      d     = 16'($urandom);
      tgt   = model_next(c, exp_pc, r_reg, i_imm);
      issue_cmd(c, sel, rdy);
      n_checks++;
      if (sel !== model_sel(c)) $display("FAIL rnd_sel[%0d]: sel=%b expected %b", t, sel, model_sel(c));
      else n_pass++;
      serve_fetch(d, lat, addr, ok);
      n_checks++;
      if ({ok, addr, ir, ir_valid} !== {1'b1, tgt, d, 1'b1})
        $display("FAIL rnd_fetch[%0d]: addr=%h ir=%h v=%b expected %h/%h/1", t, addr, ir, ir_valid, tgt, d);
      else n_pass++;
      exp_pc = tgt;
      exp_ir = d;
    end
  endtask

  task automatic test_timeout;
    logic [15:0] addr, tgt;
    logic [4:0]  sel;
    logic        ok, rdy;
    int          n;
    tgt = model_next(2'b00, exp_pc, r_reg, i_imm);
    issue_cmd(2'b00, sel, rdy);
    n = 0;
`ifdef FETCH_TIMEOUT_EN
    while (mem_read && n < 100) begin
      n++;
      @(negedge clk);
    end
    n_checks++;
    if (n !== TIMEOUT) $display("FAIL to_cycles: mem_read high %0d cycles expected %0d", n, TIMEOUT);
    else n_pass++;
    n_checks++;
    if ({fetch_err, mem_read} !== 2'b10) $display("FAIL to_flag: err=%b rd=%b expected 1/0", fetch_err, mem_read);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({mem_read, mem_addr} !== {1'b1, tgt}) $display("FAIL to_reissue: rd=%b addr=%h expected 1/%h", mem_read, mem_addr, tgt);
    else n_pass++;
    serve_fetch(16'h8888, 1, addr, ok);
    n_checks++;
    if ({ok, ir, fetch_err} !== {1'b1, 16'h8888, 1'b1}) $display("FAIL to_sticky: ir=%h err=%b expected 8888/1", ir, fetch_err);
    else n_pass++;
    soft_rst = 1'b1;
    @(negedge clk);
    soft_rst = 1'b0;
    n_checks++;
    if (fetch_err !== 1'b0) $display("FAIL to_clear: err=%b expected 0", fetch_err);
    else n_pass++;
    serve_fetch(16'h9999, 1, addr, ok);
    exp_pc = 16'h0000;
    exp_ir = 16'h9999;
`else
    for (int k = 0; k < 40; k++) begin
      if (mem_read === 1'b1 && fetch_err === 1'b0 && mem_addr === tgt) n++;
      @(negedge clk);
    end
    n_checks++;
    if (n !== 40) $display("FAIL no_timeout: %0d of 40 cycles held request expected 40", n);
    else n_pass++;
    serve_fetch(16'h8888, 1, addr, ok);
    n_checks++;
    if ({ok, addr, ir, fetch_err} !== {1'b1, tgt, 16'h8888, 1'b0})
      $display("FAIL late_ready: addr=%h ir=%h err=%b expected %h/8888/0", addr, ir, fetch_err, tgt);
    else n_pass++;
    exp_pc = tgt;
    exp_ir = 16'h8888;
`endif
  endtask

  task automatic test_async_reset;
    logic [15:0] addr;
    logic [4:0]  sel;
    logic        ok, rdy;
    r_reg = 16'h4321;
    i_imm = 16'h0102;
    issue_cmd(2'b10, sel, rdy);
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({pc_side, ir, mem_read, sel_now, cmd_ready} !== 39'h0)
      $display("FAIL async_rst: pc=%h ir=%h rd=%b sel=%b rdy=%b expected all 0", pc_side, ir, mem_read, sel_now, cmd_ready);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    serve_fetch(16'hBEEF, 1, addr, ok);
    n_checks++;
    if ({ok, addr, ir, ir_valid} !== {1'b1, 16'h0000, 16'hBEEF, 1'b1})
      $display("FAIL post_rst: addr=%h ir=%h v=%b expected 0000/beef/1", addr, ir, ir_valid);
    else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_pc = 16'h0000;
    exp_ir = 16'h0000;
    test_reset();
    test_pc_plus_1();
    test_wrap();
    test_soft_rst();
    test_cmd_during_fetch();
    test_random();
    test_timeout();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
